// File: rtl/writeback_stage.sv
// Writeback stage: commits scalar results in one cycle and serializes vector lane writes.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage (
   input  logic        CLK,
   input  logic        RST,
   input  logic [76:0] PIPELINE_M,
   input  logic        VALID_M,
   output logic        STALL,
   output logic        SRF_WE,
   output logic [3:0]  SRF_WA,
   output logic [31:0] SRF_WD,
   output logic        VRF_WE,
   output logic [3:0]  VRF_WA,
   output logic [1:0]  VRF_LANE,
   output logic [7:0]  VRF_WD,
   output logic [15:0] RETIRED
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 4;
   localparam int unsigned LANES  = 4;
   localparam int unsigned CNT_W  = 16;

   typedef struct packed {
      logic              reg_write;
      logic              mem_to_reg;
      logic              vec;
      logic [1:0]        rsvd;
      logic [REG_W-1:0]  dest;
      logic [LANES-1:0]  lane_mask;
      logic [DATA_W-1:0] alu_result;
      logic [DATA_W-1:0] read_data;
   } pipe_m_t;

   typedef enum logic {S_IDLE, S_VWRITE} state_t;

   pipe_m_t           pm;
   logic              unused_rsvd;
   logic              accept;
   logic [DATA_W-1:0] result_c;

   state_t            state_q, state_d;
   logic [LANES-1:0]  pend_q, pend_d;
   logic [REG_W-1:0]  dest_q, dest_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic [1:0]        lane;

   logic              stall_d, srf_we_d, vrf_we_d;
   logic [REG_W-1:0]  srf_wa_d, vrf_wa_d;
   logic [DATA_W-1:0] srf_wd_d;
   logic [1:0]        vrf_lane_d;
   logic [7:0]        vrf_wd_d;

   assign pm          = PIPELINE_M;
   assign unused_rsvd = ^pm.rsvd;
   assign accept      = VALID_M && !STALL;
   assign result_c    = pm.mem_to_reg ? pm.read_data : pm.alu_result;

   // Priority pick of the lowest pending lane
   function automatic logic [1:0] low_lane(input logic [LANES-1:0] m);
      if (m[0])      return 2'd0;
      else if (m[1]) return 2'd1;
      else if (m[2]) return 2'd2;
      else           return 2'd3;
   endfunction

   // Next-state and next-output logic; the first lane is issued straight from IDLE
   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      dest_d     = dest_q;
      res_d      = res_q;
      lane       = 2'd0;
      srf_we_d   = 1'b0;
      srf_wa_d   = SRF_WA;
      srf_wd_d   = SRF_WD;
      vrf_we_d   = 1'b0;
      vrf_wa_d   = VRF_WA;
      vrf_lane_d = VRF_LANE;
      vrf_wd_d   = VRF_WD;
      case (state_q)
         S_IDLE: begin
            if (accept && pm.reg_write) begin
               if (!pm.vec) begin
                  srf_we_d = 1'b1;
                  srf_wa_d = pm.dest;
                  srf_wd_d = result_c;
               end else if (pm.lane_mask != 4'd0) begin
                  lane       = low_lane(pm.lane_mask);
                  vrf_we_d   = 1'b1;
                  vrf_wa_d   = pm.dest;
                  vrf_lane_d = lane;
                  vrf_wd_d   = 8'(result_c >> {lane, 3'b000});
                  pend_d     = pm.lane_mask & ~(4'b0001 << lane);
                  dest_d     = pm.dest;
                  res_d      = result_c;
                  if (pend_d != 4'd0) state_d = S_VWRITE;
               end
            end
         end
         S_VWRITE: begin
            lane       = low_lane(pend_q);
            vrf_we_d   = 1'b1;
            vrf_wa_d   = dest_q;
            vrf_lane_d = lane;
            vrf_wd_d   = 8'(res_q >> {lane, 3'b000});
            pend_d     = pend_q & ~(4'b0001 << lane);
            if (pend_d == 4'd0) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      stall_d = (state_d == S_VWRITE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= S_IDLE;
         pend_q   <= '0;
         dest_q   <= '0;
         res_q    <= '0;
         STALL    <= 1'b0;
         SRF_WE   <= 1'b0;
         SRF_WA   <= '0;
         SRF_WD   <= '0;
         VRF_WE   <= 1'b0;
         VRF_WA   <= '0;
         VRF_LANE <= '0;
         VRF_WD   <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         dest_q   <= dest_d;
         res_q    <= res_d;
         STALL    <= stall_d;
         SRF_WE   <= srf_we_d;
         SRF_WA   <= srf_wa_d;
         SRF_WD   <= srf_wd_d;
         VRF_WE   <= vrf_we_d;
         VRF_WA   <= vrf_wa_d;
         VRF_LANE <= vrf_lane_d;
         VRF_WD   <= vrf_wd_d;
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   logic [CNT_W-1:0] retired_q;

   always_ff @(posedge CLK) begin
      if (RST)         retired_q <= '0;
      else if (accept) retired_q <= retired_q + CNT_W'(1);
   end

   assign RETIRED = retired_q;
`else
   assign RETIRED = CNT_W'(0);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized self-checking bench for writeback_stage against a queue-based port-event model.
module tb_writeback_stage;

   logic        CLK;
   logic        RST;
   logic [76:0] PIPELINE_M;
   logic        VALID_M;
   logic        STALL;
   logic        SRF_WE;
   logic [3:0]  SRF_WA;
   logic [31:0] SRF_WD;
   logic        VRF_WE;
   logic [3:0]  VRF_WA;
   logic [1:0]  VRF_LANE;
   logic [7:0]  VRF_WD;
   logic [15:0] RETIRED;

   writeback_stage dut (
      .CLK(CLK), .RST(RST), .PIPELINE_M(PIPELINE_M), .VALID_M(VALID_M),
      .STALL(STALL), .SRF_WE(SRF_WE), .SRF_WA(SRF_WA), .SRF_WD(SRF_WD),
      .VRF_WE(VRF_WE), .VRF_WA(VRF_WA), .VRF_LANE(VRF_LANE), .VRF_WD(VRF_WD),
      .RETIRED(RETIRED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic        is_vec;
      logic [3:0]  addr;
      logic [1:0]  lane;
      logic [31:0] data;
   } ev_t;

   ev_t         q[$];
   ev_t         cur;
   logic        cur_valid;
   logic [3:0]  e_srf_wa, e_vrf_wa;
   logic [31:0] e_srf_wd;
   logic [1:0]  e_vrf_lane;
   logic [7:0]  e_vrf_wd;
   logic [15:0] e_retired;
   int          checks;
   int          failures;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [76:0] mk(input logic rw, input logic m2r, input logic vec,
                                      input logic [3:0] dest, input logic [3:0] mask,
                                      input logic [31:0] alu, input logic [31:0] rd);
      return {rw, m2r, vec, 2'b00, dest, mask, alu, rd};
   endfunction

   // Model: each accepted instruction expands into a list of port events, one per cycle
   task automatic model_edge(input logic v, input logic [76:0] pm, input logic r);
      logic        acc;
      logic [31:0] res;
      ev_t         e;
      if (r) begin
         q.delete();
         cur_valid  = 1'b0;
         e_srf_wa   = '0; e_srf_wd = '0;
         e_vrf_wa   = '0; e_vrf_lane = '0; e_vrf_wd = '0;
         e_retired  = '0;
         return;
      end
      acc = v && (q.size() == 0);
      if (q.size() > 0) begin
         cur = q.pop_front();
         cur_valid = 1'b1;
      end else begin
         cur_valid = 1'b0;
         if (acc && pm[76]) begin
            res = pm[75] ? pm[31:0] : pm[63:32];
            if (!pm[74]) begin
               e.is_vec = 1'b0; e.addr = pm[71:68]; e.lane = 2'd0; e.data = res;
               q.push_back(e);
            end else begin
               for (int i = 0; i < 4; i++) begin
                  if (pm[64 + i]) begin
                     e.is_vec = 1'b1; e.addr = pm[71:68]; e.lane = 2'(i);
                     e.data = (res >> (8 * i)) & 32'hFF;
                     q.push_back(e);
                  end
               end
            end
            if (q.size() > 0) begin
               cur = q.pop_front();
               cur_valid = 1'b1;
            end
         end
      end
`ifdef WB_RETIRE_COUNT_EN
      if (acc) e_retired = e_retired + 16'd1;
`endif
      if (cur_valid) begin
         if (cur.is_vec) begin
            e_vrf_wa = cur.addr; e_vrf_lane = cur.lane; e_vrf_wd = cur.data[7:0];
         end else begin
            e_srf_wa = cur.addr; e_srf_wd = cur.data;
         end
      end
   endtask

   task automatic compare_all();
      check("srf_we",   32'(SRF_WE),   32'(cur_valid && !cur.is_vec));
      check("vrf_we",   32'(VRF_WE),   32'(cur_valid && cur.is_vec));
      check("we_excl",  32'(SRF_WE & VRF_WE), 32'd0);
      check("srf_wa",   32'(SRF_WA),   32'(e_srf_wa));
      check("srf_wd",   SRF_WD,        e_srf_wd);
      check("vrf_wa",   32'(VRF_WA),   32'(e_vrf_wa));
      check("vrf_lane", 32'(VRF_LANE), 32'(e_vrf_lane));
      check("vrf_wd",   32'(VRF_WD),   32'(e_vrf_wd));
      check("stall",    32'(STALL),    32'(q.size() > 0));
      check("retired",  32'(RETIRED),  32'(e_retired));
   endtask

   // One clock: drive at negedge, update model at posedge, sample 1 time unit later
   task automatic cycle(input logic v, input logic [76:0] pm, input logic r);
      VALID_M = v; PIPELINE_M = pm; RST = r;
      @(posedge CLK);
      model_edge(v, pm, r);
      #1;
      compare_all();
      @(negedge CLK);
   endtask

   logic [76:0] nop;

   initial begin
      checks = 0; failures = 0;
      cur_valid = 1'b0; cur = '{default: '0};
      e_retired = '0;
      VALID_M = 1'b0; PIPELINE_M = '0; RST = 1'b1;
      nop = '0;
      @(negedge CLK);
      cycle(1'b0, nop, 1'b1);
      cycle(1'b0, nop, 1'b1);
      check("rst_stall", 32'(STALL), 32'd0);

      // Scalar ALU write
      cycle(1'b1, mk(1, 0, 0, 4'd5, 4'd0, 32'h12345678, 32'h0), 1'b0);
      check("scalar_wd", SRF_WD, 32'h12345678);
      cycle(1'b0, nop, 1'b0);

      // Back-to-back loads
      cycle(1'b1, mk(1, 1, 0, 4'd3, 4'd0, 32'h0, 32'hCAFEBABE), 1'b0);
      cycle(1'b1, mk(1, 1, 0, 4'd4, 4'd0, 32'h0, 32'hCAFEBABE), 1'b0);
      cycle(1'b1, mk(1, 1, 0, 4'd6, 4'd0, 32'h0, 32'hCAFEBABE), 1'b0);
      check("load3_wa", 32'(SRF_WA), 32'd6);

      // Full vector followed by a held scalar
      cycle(1'b1, mk(1, 0, 1, 4'd2, 4'hF, 32'hA1B2C3D4, 32'h0), 1'b0);
      check("vec_lane0", 32'(VRF_WD), 32'hD4);
      for (int i = 0; i < 3; i++) cycle(1'b1, mk(1, 0, 0, 4'd9, 4'd0, 32'h55, 32'h0), 1'b0);
      check("vec_lane3", 32'(VRF_WD), 32'hA1);
      cycle(1'b1, mk(1, 0, 0, 4'd9, 4'd0, 32'h55, 32'h0), 1'b0);
      check("held_scalar", 32'(SRF_WA), 32'd9);

      // Sparse and empty masks
      cycle(1'b1, mk(1, 0, 1, 4'd7, 4'b1010, 32'h11223344, 32'h0), 1'b0);
      check("sparse_l1", 32'(VRF_WD), 32'h33);
      cycle(1'b1, mk(1, 0, 1, 4'd8, 4'b0000, 32'h99, 32'h0), 1'b0);
      check("sparse_l3", 32'(VRF_WD), 32'h11);
      cycle(1'b1, mk(1, 0, 1, 4'd8, 4'b0000, 32'h99, 32'h0), 1'b0);
      check("empty_mask_we", 32'(VRF_WE | SRF_WE), 32'd0);
      cycle(1'b0, nop, 1'b0);

      // Reset during the second lane
      cycle(1'b1, mk(1, 0, 1, 4'd1, 4'hF, 32'hDEADBEEF, 32'h0), 1'b0);
      cycle(1'b0, nop, 1'b0);
      cycle(1'b0, nop, 1'b1);
      check("rst_mid_we", 32'(VRF_WE), 32'd0);
      for (int i = 0; i < 3; i++) cycle(1'b0, nop, 1'b0);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         logic [76:0] pm;
         logic        v, r;
         pm = {$urandom(), $urandom(), 13'($urandom())};
         v  = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 199) == 0);
         cycle(v, pm, r);
      end

`ifdef WB_RETIRE_COUNT_EN
      // Retire counter wrap
      cycle(1'b0, nop, 1'b1);
      for (int i = 0; i < 65535; i++) cycle(1'b1, nop, 1'b0);
      check("ret_ffff", 32'(RETIRED), 32'hFFFF);
      cycle(1'b0, nop, 1'b0);
      check("ret_idle_hold", 32'(RETIRED), 32'hFFFF);
      cycle(1'b1, nop, 1'b0);
      check("ret_wrap", 32'(RETIRED), 32'h0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the vector ASIP. Consumes the 77-bit memory-stage pipeline register and the matching valid flag, selects ALU or memory data, and commits it to the scalar register file in one cycle or to the 8-bit-lane vector register file one lane per cycle. Multi-lane vector writes are serialized by a small state machine that back-pressures the upstream pipeline with STALL.

## Interface
Parameters:
- none; all widths are fixed by the pipeline format.

Ports (name, direction, width, meaning):
- Clocking and reset: one clock; reset is synchronous and active-high.
  - CLK  input  1  clock; all state updates on the rising edge.
  - RST  input  1  synchronous, active-high reset.
- Pipeline input:
  - PIPELINE_M  input  77  memory-stage bundle:
    - [76] REG_WRITE
    - [75] MEM_TO_REG
    - [74] VEC
    - [73:72] reserved, ignored
    - [71:68] DEST
    - [67:64] LANE_MASK
    - [63:32] ALU_RESULT
    - [31:0] READ_DATA
  - VALID_M  input  1  PIPELINE_M holds a real instruction.
- Back-pressure:
  - STALL  output  1  upstream must hold PIPELINE_M/VALID_M; input not accepted.
- Scalar register-file write port:
  - SRF_WE  output  1  scalar register-file write enable.
  - SRF_WA  output  4  scalar write address.
  - SRF_WD  output  32  scalar write data.
- Vector register-file write port:
  - VRF_WE  output  1  vector register-file write enable.
  - VRF_WA  output  4  vector register index.
  - VRF_LANE  output  2  lane being written.
  - VRF_WD  output  8  lane data.
- Retire counter:
  - RETIRED  output  16  retired-instruction count (see Configuration).

## Operation
- Accept condition:
  - The input is accepted on a rising edge when VALID_M=1 and STALL=0.
  - Inputs are ignored while STALL=1 or VALID_M=0.
- Result selection: RESULT = MEM_TO_REG ? READ_DATA : ALU_RESULT, computed at acceptance and captured in a holding register.
- State machine:
  - IDLE:
    - Accepting with REG_WRITE=1, VEC=0 drives one scalar write: SRF_WE=1, SRF_WA=DEST, SRF_WD=RESULT. Stay IDLE.
    - Accepting with REG_WRITE=1, VEC=1, LANE_MASK≠0 latches DEST, RESULT and LANE_MASK, then goes to VWRITE.
    - Accepting with REG_WRITE=0, or VEC=1 with LANE_MASK=0, performs no write. The instruction still retires.
  - VWRITE:
    - Each cycle writes the lowest set bit i of the pending mask: VRF_WE=1, VRF_WA=DEST, VRF_LANE=i, VRF_WD=RESULT[8i+7:8i].
    - That mask bit is then cleared.
    - When the last lane is written, return to IDLE.
- STALL is a function of registered state only: 1 when the pending mask, after the lane currently on the port, is non-zero; 0 otherwise.
- A new instruction is accepted on the edge that ends the final lane write, so there is no bubble between instructions.
- SRF_WE and VRF_WE are never both 1 in the same cycle.
- Reset:
  - All outputs are 0, the state is IDLE, and the pending mask is 0.
  - Reset during VWRITE discards the remaining lanes.
  - Reset takes priority over a simultaneous accept.

## Timing
- All write-port outputs are registered.
- An instruction accepted at edge k drives its scalar write, or its first vector lane, during cycle k+1.
- A vector write with n set mask bits drives lanes in cycles k+1..k+n, in ascending lane order.
- STALL is 1 during cycles k+1..k+n-1 and is never asserted for scalar writes.
- Throughput:
  - Scalar and no-write instructions: 1 per cycle.
  - Vector writes: 1 instruction per popcount(LANE_MASK) cycles.
- Write-enable pulses last exactly one cycle per write. Address and data outputs hold their last values when the enables are 0.

## Configuration
- WB_RETIRE_COUNT_EN defined:
  - RETIRED counts accepted instructions.
  - Each accept increments it by 1 on the accept edge, so the new value is visible in the next cycle.
  - It wraps modulo 2^16 (0xFFFF → 0x0000) and resets to 0.
- WB_RETIRE_COUNT_EN not defined: RETIRED is tied to 0 and no counter flops are generated.

## Test plan
- Scalar ALU write: VALID_M=1, REG_WRITE=1, MEM_TO_REG=0, VEC=0, DEST=5, ALU_RESULT=0x12345678 -> next cycle SRF_WE=1, SRF_WA=5, SRF_WD=0x12345678; STALL stays 0.
- Load writeback, back-to-back scalars:
  - Stimulus: MEM_TO_REG=1, READ_DATA=0xCAFEBABE, DEST=3 on consecutive cycles with DEST 3, 4, 6.
  - Response: SRF_WE=1 for three consecutive cycles, SRF_WA=3, 4, 6, SRF_WD=0xCAFEBABE.
- Full vector write: VEC=1, LANE_MASK=1111, DEST=2, ALU_RESULT=0xA1B2C3D4 -> VRF_LANE 0..3 with VRF_WD 0xD4, 0xC3, 0xB2, 0xA1 over four cycles; STALL=1 for the first three of those cycles; the held next instruction is written in the fifth cycle.
- Sparse and empty masks:
  - LANE_MASK=1010, RESULT=0x11223344 -> lane 1=0x33 then lane 3=0x11 (2 cycles, 1 stall cycle).
  - LANE_MASK=0000 -> no write, no stall.
- Reset mid-vector: RST=1 during the second lane of LANE_MASK=1111 -> next cycle all write enables are 0, STALL=0, state IDLE, and no further lanes are written.
- Retire counter (WB_RETIRE_COUNT_EN defined):
  - Preload by issuing 65535 accepts, then one more -> RETIRED goes 0xFFFF → 0x0000.
  - Stalled cycles and VALID_M=0 cycles do not increment RETIRED.
